capture_dram_ctrl: RTL

Parametrised sniffer-capture DRAM controller, next generation of the single-channel trigger capture controller. It stores WORDS-word samples from the bus sniffer into a configurable DRAM window, in one of two modes: one-shot (trigger then fill) or circular pre-trigger (arm, wrap, stop a programmable number of samples after trigger). It shares the single DRAM request port with a host readback path, and reports trigger position, completion and dropped samples.

---
 rtl/capture_dram_ctrl.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/capture_dram_ctrl.sv
`timescale 1ns / 1ps
// capture_dram_ctrl
// Stores multi-word sniffer samples into a DRAM window, in one of two modes:
// one-shot (trigger, then fill the window) or circular (arm, record around the window,
// stop a programmable number of samples after trigger). It shares the single DRAM
// request port with a host readback path.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   o_dram_req/i_dram_ack   request held until the one-cycle acknowledge
//   o_dram_addr/we/data     request address, direction (1 = write), write data
//   i_sample_data/stb       WORDS*DATA_W sample, valid with the one-cycle strobe
//   i_mode, i_arm           0 = one-shot, 1 = circular; arm starts circular recording
//   i_trigger, i_post_count trigger pulse; circular samples to store after trigger
//   i_rd_addr(_changed)     readback address and read request pulse
//   o_wr_en, o_done         capture active; capture finished (sticky)
//   o_trig_addr, o_overrun  address of the trigger sample; sticky sample-drop flag
module capture_dram_ctrl #(
  parameter int unsigned       ADDR_W  = 24,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       WORDS   = 2,
  parameter logic [ADDR_W-1:0] BASE    = 24'h000000,
  parameter logic [ADDR_W-1:0] DEPTH   = 24'h600000,
  parameter logic [ADDR_W-1:0] RD_BASE = 24'h600000,
  parameter int unsigned       RD_W    = 22
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  output logic                    o_dram_req,
  input  logic                    i_dram_ack,
  output logic [ADDR_W-1:0]       o_dram_addr,
  output logic                    o_dram_we,
  output logic [DATA_W-1:0]       o_dram_data,
  input  logic [WORDS*DATA_W-1:0] i_sample_data,
  input  logic                    i_sample_stb,
  input  logic                    i_mode,
  input  logic                    i_arm,
  input  logic                    i_trigger,
  input  logic [15:0]             i_post_count,
  input  logic [RD_W-1:0]         i_rd_addr,
  input  logic                    i_rd_addr_changed,
  output logic                    o_wr_en,
  output logic                    o_done,
  output logic [ADDR_W-1:0]       o_trig_addr,
  output logic                    o_overrun
);

  localparam int unsigned       K_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [K_W-1:0]    K_LAST   = K_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_OFF = DEPTH - ADDR_W'(1);

  typedef enum logic [1:0] {StDispatch, StWrWait, StWrGap, StRdWait} state_e;

  state_e                  r_state,     w_state_nxt;
  logic                    r_req,       w_req_nxt;
  logic [ADDR_W-1:0]       r_addr,      w_addr_nxt;
  logic                    r_we,        w_we_nxt;
  logic [DATA_W-1:0]       r_data,      w_data_nxt;
  logic                    r_wr_en,     w_wr_en_nxt;
  logic                    r_done,      w_done_nxt;
  logic [ADDR_W-1:0]       r_trig_addr, w_trig_addr_nxt;
  logic                    r_overrun,   w_overrun_nxt;
  logic [ADDR_W-1:0]       r_offset,    w_offset_nxt;
  logic [ADDR_W-1:0]       r_samp_off,  w_samp_off_nxt;
  logic [K_W-1:0]          r_k,         w_k_nxt;
  logic [WORDS*DATA_W-1:0] r_buf,       w_buf_nxt;
  logic                    r_pend,      w_pend_nxt;
  logic                    r_rd_pend,   w_rd_pend_nxt;
  logic                    r_mode,      w_mode_nxt;
  logic                    r_triggered, w_triggered_nxt;
  logic [15:0]             r_post,      w_post_nxt;

  logic              w_wrap, w_in_write, w_complete;
  logic              w_start_one, w_start_circ, w_trig_circ;
  logic [K_W-1:0]    w_k_sel;
  logic [DATA_W-1:0] w_word;
  logic [15:0]       w_post_dec;

  assign w_wrap       = (r_offset == LAST_OFF);
  assign w_in_write   = (r_state == StWrWait) || (r_state == StWrGap);
  assign w_complete   = (r_state == StWrWait) && i_dram_ack && (r_k == '0);
  assign w_start_one  = i_trigger && !r_wr_en && !i_mode;
  assign w_start_circ = i_arm && !r_wr_en && i_mode;
  assign w_trig_circ  = i_trigger && r_wr_en && r_mode && !r_triggered;
  assign w_post_dec   = (r_post == 16'd0) ? 16'd0 : r_post - 16'd1;
  // Most-significant word leaves first; r_k is already decremented when in WR_GAP.
  assign w_k_sel      = (r_state == StWrGap) ? r_k : K_LAST;
  assign w_word       = r_buf[w_k_sel*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_addr_nxt      = r_addr;
    w_we_nxt        = r_we;
    w_data_nxt      = r_data;
    w_wr_en_nxt     = r_wr_en;
    w_done_nxt      = r_done;
    w_trig_addr_nxt = r_trig_addr;
    w_overrun_nxt   = r_overrun;
    w_offset_nxt    = r_offset;
    w_samp_off_nxt  = r_samp_off;
    w_k_nxt         = r_k;
    w_buf_nxt       = r_buf;
    w_pend_nxt      = r_pend;
    w_rd_pend_nxt   = r_rd_pend | i_rd_addr_changed;
    w_mode_nxt      = r_mode;
    w_triggered_nxt = r_triggered;
    w_post_nxt      = r_post;

    // Single holding buffer: it stays occupied until the last word of its sample is acked.
    if (i_sample_stb && r_wr_en) begin
      if (!r_pend) begin
        w_buf_nxt  = i_sample_data;
        w_pend_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end

    if (w_trig_circ) begin
      w_triggered_nxt = 1'b1;
      w_trig_addr_nxt = BASE + (w_in_write ? r_samp_off : r_offset);
      w_post_nxt      = i_post_count;
      // Zero post count with nothing left to finish stops right away.
      if (i_post_count == 16'd0 && (!r_pend || w_complete)) begin
        w_wr_en_nxt = 1'b0;
        w_done_nxt  = 1'b1;
        w_pend_nxt  = 1'b0;
      end
    end

    unique case (r_state)
      StDispatch: begin
        if (r_rd_pend) begin
          w_req_nxt     = 1'b1;
          w_we_nxt      = 1'b0;
          w_addr_nxt    = RD_BASE | ADDR_W'(i_rd_addr);
          w_rd_pend_nxt = i_rd_addr_changed;
          w_state_nxt   = StRdWait;
        end else if (r_pend) begin
          w_req_nxt      = 1'b1;
          w_we_nxt       = 1'b1;
          w_addr_nxt     = BASE + r_offset;
          w_data_nxt     = w_word;
          w_k_nxt        = K_LAST;
          w_samp_off_nxt = r_offset;
          w_state_nxt    = StWrWait;
        end
      end
      StWrWait: begin
        if (i_dram_ack) begin
          w_req_nxt    = 1'b0;
          w_we_nxt     = 1'b0;
          w_addr_nxt   = '0;
          w_offset_nxt = w_wrap ? '0 : r_offset + ADDR_W'(1);
          if (r_k != '0) begin
            w_k_nxt     = r_k - K_W'(1);
            w_state_nxt = StWrGap;
          end else begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = StDispatch;
            // DEPTH is a multiple of WORDS, so the window end always falls on a sample end.
            if (!r_mode && w_wrap) begin
              w_wr_en_nxt = 1'b0;
              w_done_nxt  = 1'b1;
            end
            if (r_mode && r_triggered) begin
              w_post_nxt = w_post_dec;
              if (w_post_dec == 16'd0) begin
                w_wr_en_nxt = 1'b0;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
      end
      StWrGap: begin
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = BASE + r_offset;
        w_data_nxt  = w_word;
        w_state_nxt = StWrWait;
      end
      StRdWait: begin
        if (i_dram_ack) begin
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = '0;
          w_state_nxt = StDispatch;
        end
      end
      default: w_state_nxt = StDispatch;
    endcase

    // Starts only happen with wr_en=0, when no sample write is in flight.
    if (w_start_one) begin
      w_wr_en_nxt     = 1'b1;
      w_offset_nxt    = '0;
      w_trig_addr_nxt = BASE;
      w_done_nxt      = 1'b0;
      w_overrun_nxt   = 1'b0;
      w_mode_nxt      = 1'b0;
      w_triggered_nxt = 1'b0;
    end else if (w_start_circ) begin
      w_wr_en_nxt     = 1'b1;
      w_offset_nxt    = '0;
      w_done_nxt      = 1'b0;
      w_overrun_nxt   = 1'b0;
      w_mode_nxt      = 1'b1;
      w_triggered_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StDispatch;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_data      <= '0;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_trig_addr <= '0;
      r_overrun   <= 1'b0;
      r_offset    <= '0;
      r_samp_off  <= '0;
      r_k         <= '0;
      r_buf       <= '0;
      r_pend      <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_mode      <= 1'b0;
      r_triggered <= 1'b0;
      r_post      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_addr      <= w_addr_nxt;
      r_we        <= w_we_nxt;
      r_data      <= w_data_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_done      <= w_done_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_overrun   <= w_overrun_nxt;
      r_offset    <= w_offset_nxt;
      r_samp_off  <= w_samp_off_nxt;
      r_k         <= w_k_nxt;
      r_buf       <= w_buf_nxt;
      r_pend      <= w_pend_nxt;
      r_rd_pend   <= w_rd_pend_nxt;
      r_mode      <= w_mode_nxt;
      r_triggered <= w_triggered_nxt;
      r_post      <= w_post_nxt;
    end
  end

  assign o_dram_req  = r_req;
  assign o_dram_addr = r_addr;
  assign o_dram_we   = r_we;
  assign o_dram_data = r_data;
  assign o_wr_en     = r_wr_en;
  assign o_done      = r_done;
  assign o_trig_addr = r_trig_addr;
  assign o_overrun   = r_overrun;

endmodule
